// File: rtl/fetch_aligner_if.sv
// fetch_aligner_if: redirect, instruction-memory and decode handshake signals of the fetch aligner.
interface fetch_aligner_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_c;
  modport master (
    input  redirect, redirect_pc, mem_valid, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc, inst_is_c
  );
  modport slave (
    output redirect, redirect_pc, mem_valid, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, inst_is_c
  );
endinterface

// File: rtl/fetch_aligner.sv
// fetch_aligner: word fetcher and halfword aligner presenting 16/32-bit instructions to decode.
// Defining FETCH_ALIGNER_PERF_EN adds the stall_cnt decode-starvation counter port.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  fetch_aligner_if.master bus
`ifdef FETCH_ALIGNER_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  logic [63:0] hbuf, hbuf_d;
  logic [2:0]  hcnt, hcnt_d, pop, push, keep;
  logic [31:0] fetch_addr, head_pc;
  logic        outstanding, drop, skip_low;
  logic        is_c, valid, req, resp;
  logic [15:0] first_hw;
  assign is_c     = hcnt != 3'd0 && hbuf[1:0] != 2'b11;
  assign valid    = is_c || hcnt >= 3'd2;
  // one request in flight, and only when a whole word still fits
  assign req      = !reset && !bus.redirect && !outstanding && hcnt <= 3'd2;
  assign resp     = bus.mem_valid && !bus.redirect && !drop;
  assign pop      = valid && bus.inst_ready && !bus.redirect ? (is_c ? 3'd1 : 3'd2) : 3'd0;
  assign push     = resp ? (skip_low ? 3'd1 : 3'd2) : 3'd0;
  assign keep     = hcnt - pop;
  assign hcnt_d   = keep + push;
  assign first_hw = skip_low ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign bus.mem_req    = req;
  assign bus.mem_addr   = fetch_addr;
  assign bus.inst_valid = valid;
  assign bus.inst_is_c  = is_c;
  assign bus.inst       = is_c ? {16'h0, hbuf[15:0]} : hbuf[31:0];
  assign bus.inst_pc    = head_pc;
  always_comb begin
    hbuf_d = hbuf >> {pop, 4'b0};
    for (int i = 0; i < 4; i++) begin
      if (push != 3'd0 && 3'(i) == keep) hbuf_d[16*i +: 16] = first_hw;
      if (push == 3'd2 && 3'(i) == keep + 3'd1) hbuf_d[16*i +: 16] = bus.mem_rdata[31:16];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hbuf        <= 64'd0;
      hcnt        <= 3'd0;
      fetch_addr  <= RESET_PC & ~32'h3;
      head_pc     <= RESET_PC;
      skip_low    <= RESET_PC[1];
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (bus.redirect) begin
      hcnt        <= 3'd0;
      head_pc     <= bus.redirect_pc & ~32'h1;
      fetch_addr  <= bus.redirect_pc & ~32'h3;
      skip_low    <= bus.redirect_pc[1];
      // a request still in flight must be swallowed when it returns
      outstanding <= outstanding && !bus.mem_valid;
      drop        <= outstanding && !bus.mem_valid;
    end else begin
      hbuf        <= hbuf_d;
      hcnt        <= hcnt_d;
      head_pc     <= head_pc + {28'd0, pop, 1'b0};
      fetch_addr  <= fetch_addr + (req ? 32'd4 : 32'd0);
      outstanding <= req || (outstanding && !bus.mem_valid);
      drop        <= drop && !bus.mem_valid;
      if (resp) skip_low <= 1'b0;
    end
  end
`ifdef FETCH_ALIGNER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= 32'd0;
    else if (bus.inst_ready && !valid) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: directed stimulus with a scoreboard of expected accepted instructions.
module tb_fetch_aligner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fetch_aligner_if bus();
`ifdef FETCH_ALIGNER_PERF_EN
  logic [31:0] stall_cnt;
  fetch_aligner dut (.clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt));
`else
  fetch_aligner dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
  } exp_t;
  exp_t sb[$];
  exp_t got, want;
  int total = 0;
  int bad = 0;
  int mem_lat = 1;
  int dly = 0;
  logic pend = 1'b0;
  logic [31:0] paddr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h000: return 32'h00A0_0093;
      32'h004: return 32'h4505_0001;
      32'h008: return 32'hB383_0001;
      32'h00C: return 32'h0000_0062;
      32'h010: return 32'h00A0_0513;
      32'h014: return 32'h4585_4501;
      32'h018: return 32'h00B0_0593;
      32'h01C: return 32'h1234_5678;
      32'h100: return 32'h4505_FFFF;
      32'h104: return 32'h4591_4581;
      32'h108: return 32'h0000_0001;
      32'h200: return 32'h0000_0013;
      default: return 32'h0000_0001;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_inst(input logic [31:0] i, input logic [31:0] p, input logic c);
    sb.push_back('{inst: i, pc: p, is_c: c});
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"}, bus.inst, 32'd0);
    chk({tag, "_inst_pc"}, bus.inst_pc, 32'd0);
    chk({tag, "_inst_is_c"}, 32'(bus.inst_is_c), 32'd0);
  endtask

  // memory: request seen mid-cycle, answered mem_lat cycles later
  always @(negedge clk)
    if (!reset && bus.mem_req) begin
      pend = 1'b1;
      paddr = bus.mem_addr;
      dly = mem_lat;
    end

  always @(posedge clk) begin
    #1;
    bus.mem_valid = 1'b0;
    if (reset) pend = 1'b0;
    else if (pend) begin
      if (dly <= 1) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = mem_word(paddr);
        pend = 1'b0;
      end else dly--;
    end
  end

  always @(negedge clk)
    if (!reset && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
      got = '{inst: bus.inst, pc: bus.inst_pc, is_c: bus.inst_is_c};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_inst: got inst %h pc %h expected none", got.inst, got.pc);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL accepted_inst: got inst %h pc %h c %b expected inst %h pc %h c %b",
                   got.inst, got.pc, got.is_c, want.inst, want.pc, want.is_c);
        end
      end
    end

  initial begin
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.inst_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    smp;
    chk_reset_outputs("reset");
    expect_inst(32'h00A0_0093, 32'h00, 1'b0);
    expect_inst(32'h0000_0001, 32'h04, 1'b1);
    expect_inst(32'h0000_4505, 32'h06, 1'b1);
    expect_inst(32'h0000_0001, 32'h08, 1'b1);
    expect_inst(32'h0062_B383, 32'h0A, 1'b0);
    expect_inst(32'h0000_0000, 32'h0E, 1'b1);
    expect_inst(32'h00A0_0513, 32'h10, 1'b0);
    expect_inst(32'h0000_4501, 32'h14, 1'b1);
    expect_inst(32'h0000_4585, 32'h16, 1'b1);
    cyc;
    reset = 1'b0;
    bus.inst_ready = 1'b1;
    smp;
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", bus.mem_addr, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      cyc;
      if (k == 3 || k == 7) begin
        smp;
        chk(k == 7 ? "straddle_wait" : "resp_wait", 32'(bus.inst_valid), 32'd0);
      end
    end
    bus.inst_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc;
      smp;
      chk("hold_valid", 32'(bus.inst_valid), 32'd1);
      chk("hold_inst", bus.inst, 32'h00A0_0513);
      chk("hold_pc", bus.inst_pc, 32'h10);
      if (k >= 2) chk("hold_no_req", 32'(bus.mem_req), 32'd0);
    end
    cyc;
    bus.inst_ready = 1'b1;
    cyc;
    cyc;
    cyc;
    bus.inst_ready = 1'b0;
    mem_lat = 3;
    smp;
    chk("resume_req", 32'(bus.mem_req), 32'd1);
    chk("resume_addr", bus.mem_addr, 32'h1C);
    cyc;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    expect_inst(32'h0000_4505, 32'h102, 1'b1);
    smp;
    chk("redirect_cycle_req", 32'(bus.mem_req), 32'd0);
    cyc;
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b1;
    smp;
    chk("stale_wait_req", 32'(bus.mem_req), 32'd0);
    chk("stale_wait_valid", 32'(bus.inst_valid), 32'd0);
    cyc;
    mem_lat = 1;
    smp;
    chk("stale_resp_req", 32'(bus.mem_req), 32'd0);
    cyc;
    smp;
    chk("redir_req", 32'(bus.mem_req), 32'd1);
    chk("redir_addr", bus.mem_addr, 32'h100);
    cyc;
    smp;
    chk("redir_wait_valid", 32'(bus.inst_valid), 32'd0);
    cyc;
    smp;
    chk("redir_first_pc", bus.inst_pc, 32'h102);
    cyc;
    bus.inst_ready = 1'b0;
    repeat (5) cyc;
    smp;
    chk("full_no_req", 32'(bus.mem_req), 32'd0);
    chk("full_inst", bus.inst, 32'h0000_4581);
    chk("full_pc", bus.inst_pc, 32'h104);
    chk("full_is_c", 32'(bus.inst_is_c), 32'd1);
    expect_inst(32'h0000_0013, 32'h200, 1'b0);
    cyc;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    bus.inst_ready = 1'b1;
    cyc;
    bus.redirect = 1'b0;
    smp;
    chk("lat_req", 32'(bus.mem_req), 32'd1);
    chk("lat_addr", bus.mem_addr, 32'h200);
    chk("lat_valid_n1", 32'(bus.inst_valid), 32'd0);
    cyc;
    smp;
    chk("lat_valid_n2", 32'(bus.inst_valid), 32'd0);
    cyc;
    smp;
    chk("lat_valid_n3", 32'(bus.inst_valid), 32'd1);
    chk("lat_pc_n3", bus.inst_pc, 32'h200);
    cyc;
    bus.inst_ready = 1'b0;
    cyc;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("midreset");
    chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef FETCH_ALIGNER_PERF_EN
    mem_lat = 20;
    cyc;
    cyc;
    reset = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (4) cyc;
    cyc;
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    smp;
    chk("stall_cnt", stall_cnt, 32'd5);
    cyc;
    bus.redirect = 1'b0;
    smp;
    chk("stall_cnt_after_redirect", stall_cnt, 32'd5);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
